buzzer_music_player: RTL

Consumer side of the bus-side buzzer music control interface. It takes the one-cycle `music_start` / `music_select` command from the AHB-Lite buzzer register and plays a stored melody on a single square-wave buzzer pin. The melody is stepped note by note from an internal song ROM. The block sits between the buzzer register slave and the board buzzer pad, and reports `busy`/`done` status back for software polling.

---
 rtl/buzzer_music_pkg.sv | 96 +++++++++
 rtl/buzzer_music_player_if.sv | 20 ++
 rtl/buzzer_tone_gen.sv | 32 +++
 rtl/buzzer_music_player.sv | 136 +++++++++++++
 4 files changed

// File: rtl/buzzer_music_pkg.sv
// Shared definitions for the buzzer music player: note codes, the 50 MHz
// half-period table, the song ROM contents and the sequencer state type.
package buzzer_music_pkg;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_END  = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PLAY,
    GAP
  } state_e;

  // Useful fields of an 8-bit ROM word {code[7:4], reserved[3:2], dur-1[1:0]}.
  typedef struct packed {
    logic [3:0] code;
    logic [1:0] dur;
  } note_t;

  function automatic note_t note_entry(input logic [3:0] code, input logic [1:0] dur);
    note_t n;
    n.code = code;
    n.dur  = dur;
    return n;
  endfunction

  // Half-period in HCLK cycles at 50 MHz for codes 1..14 (C4..B5 diatonic).
  function automatic logic [16:0] half_period(input logic [3:0] code);
    logic [16:0] h;
    case (code)
      4'd1:    h = 17'd95556;
      4'd2:    h = 17'd85131;
      4'd3:    h = 17'd75843;
      4'd4:    h = 17'd71586;
      4'd5:    h = 17'd63776;
      4'd6:    h = 17'd56818;
      4'd7:    h = 17'd50620;
      4'd8:    h = 17'd47778;
      4'd9:    h = 17'd42566;
      4'd10:   h = 17'd37921;
      4'd11:   h = 17'd35793;
      4'd12:   h = 17'd31888;
      4'd13:   h = 17'd28409;
      4'd14:   h = 17'd25310;
      default: h = 17'd0;
    endcase
    return h;
  endfunction

  // Unlisted entries read as END so a short song terminates cleanly.
  function automatic note_t song_rom(input logic [1:0] song, input logic [3:0] idx);
    note_t r;
    r = note_entry(NOTE_END, 2'd0);
    case (song)
      2'd1:
        case (idx)
          4'd0:    r = note_entry(4'd6,  2'd0);
          4'd1:    r = note_entry(4'd8,  2'd1);
          4'd2:    r = note_entry(4'd10, 2'd0);
          4'd3:    r = note_entry(NOTE_REST, 2'd0);
          4'd4:    r = note_entry(4'd5,  2'd3);
          default: ;
        endcase
      2'd2:
        case (idx)
          4'd0:    r = note_entry(4'd3, 2'd1);
          4'd1:    r = note_entry(NOTE_REST, 2'd0);
          4'd2:    r = note_entry(4'd5, 2'd0);
          default: ;
        endcase
      2'd3:
        case (idx)
          4'd0:    r = note_entry(4'd1,  2'd0);
          4'd1:    r = note_entry(4'd2,  2'd1);
          4'd2:    r = note_entry(4'd3,  2'd2);
          4'd3:    r = note_entry(4'd4,  2'd3);
          4'd4:    r = note_entry(4'd5,  2'd0);
          4'd5:    r = note_entry(4'd6,  2'd1);
          4'd6:    r = note_entry(4'd7,  2'd2);
          4'd7:    r = note_entry(4'd8,  2'd3);
          4'd8:    r = note_entry(4'd9,  2'd0);
          4'd9:    r = note_entry(4'd10, 2'd1);
          4'd10:   r = note_entry(4'd11, 2'd2);
          4'd11:   r = note_entry(4'd12, 2'd3);
          4'd12:   r = note_entry(4'd13, 2'd0);
          4'd13:   r = note_entry(4'd14, 2'd1);
          4'd14:   r = note_entry(NOTE_REST, 2'd2);
          default: r = note_entry(4'd14, 2'd3);
        endcase
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/buzzer_music_player_if.sv
// Command/status link between the buzzer register slave (master side) and
// the music player (slave side).
interface buzzer_music_player_if;
  logic       music_start;
  logic [1:0] music_select;
  logic       busy;
  logic       done;
  logic [1:0] cur_song;
  logic [3:0] note_idx;

  modport master (
    output music_start, music_select,
    input  busy, done, cur_song, note_idx
  );

  modport slave (
    input  music_start, music_select,
    output busy, done, cur_song, note_idx
  );
endinterface

// File: rtl/buzzer_tone_gen.sv
// Square-wave generator: toggles wave every `half` enabled cycles; clear
// forces the counter and wave back to zero.
module buzzer_tone_gen (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        enable,
  input  logic        clear,
  input  logic [16:0] half,
  output logic        wave
);

  logic [16:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (enable) begin
      if (cnt >= half - 17'd1) begin
        cnt  <= '0;
        wave <= ~wave;
      end else begin
        cnt <= cnt + 17'd1;
      end
    end
  end

endmodule

// File: rtl/buzzer_music_player.sv
// Steps a stored melody note by note and drives a square wave on the buzzer
// pad; reports busy/done/cur_song/note_idx for software polling.
module buzzer_music_player
  import buzzer_music_pkg::*;
#(
  parameter int BEAT_CYCLES    = 12500000,
  parameter int GAP_CYCLES     = 500000,
  parameter int SONG_LEN       = 16,
  parameter int TONE_DIV_SHIFT = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  buzzer_music_player_if.slave  bus,
  output logic                  buzzer
);

  localparam int         DUR_W    = $clog2(4 * BEAT_CYCLES);
  localparam int         GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [3:0] LAST_IDX = 4'(SONG_LEN - 1);

  state_e             state, state_next;
  note_t              fetch;
  logic [16:0]        half_shifted;
  logic [16:0]        half;
  logic [3:0]         code;
  logic [DUR_W-1:0]   dur_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               cmd, cmd_song, finish;
  logic               tone_en, tone_clear;

  assign fetch        = song_rom(bus.cur_song, bus.note_idx);
  assign half_shifted = half_period(fetch.code) >> TONE_DIV_SHIFT;
  assign cmd          = bus.music_start;
  assign cmd_song     = (bus.music_select != 2'd0);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= IDLE;
    else        state <= state_next;
  end

  // A command always overrides natural completion, which suppresses done.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
    state_next = state;
    finish     = 1'b0;
    if (cmd) begin
      state_next = cmd_song ? FETCH : IDLE;
    end else begin
      case (state)
        FETCH: begin
          if (fetch.code == NOTE_END) begin
            state_next = IDLE;
            finish     = 1'b1;
          end else begin
            state_next = PLAY;
          end
        end
        PLAY: if (dur_cnt == '0) state_next = GAP;
        GAP: begin
          if (gap_cnt == '0) begin
            if (bus.note_idx == LAST_IDX) begin
              state_next = IDLE;
              finish     = 1'b1;
            end else begin
              state_next = FETCH;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.cur_song <= 2'd0;
      bus.note_idx <= 4'd0;
      code         <= NOTE_REST;
      half         <= 17'd1;
      dur_cnt      <= '0;
      gap_cnt      <= '0;
    end else begin
      bus.done <= finish;
      if (cmd) begin
        bus.busy     <= cmd_song;
        bus.cur_song <= bus.music_select;
        if (cmd_song) bus.note_idx <= 4'd0;
      end else begin
        case (state)
          FETCH: begin
            if (finish) begin
              bus.busy     <= 1'b0;
              bus.cur_song <= 2'd0;
            end else begin
              code    <= fetch.code;
              dur_cnt <= DUR_W'((int'(fetch.dur) + 1) * BEAT_CYCLES - 1);
              half    <= (half_shifted == 17'd0) ? 17'd1 : half_shifted;
            end
          end
          PLAY: begin
            if (dur_cnt != '0) dur_cnt <= dur_cnt - DUR_W'(1);
            else               gap_cnt <= GAP_W'(GAP_CYCLES - 1);
          end
          GAP: begin
            if (gap_cnt != '0) begin
              gap_cnt <= gap_cnt - GAP_W'(1);
            end else if (finish) begin
              bus.busy     <= 1'b0;
              bus.cur_song <= 2'd0;
            end else begin
              bus.note_idx <= bus.note_idx + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Wave is cleared on every cycle that does not stay in PLAY, so each note
  // starts low and the pad is silent in FETCH, GAP and IDLE.
  assign tone_en    = (state == PLAY) && (code != NOTE_REST);
  assign tone_clear = !((state == PLAY) && (state_next == PLAY));

  buzzer_tone_gen u_tone (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .enable (tone_en),
    .clear  (tone_clear),
    .half   (half),
    .wave   (buzzer)
  );

endmodule
